// File: rtl/wb_retire_unit_if.sv
// rtl/wb_retire_unit_if.sv - retire bus between MEM, the write-back stage, regfile/ID bypass and debug trace
// Purpose: bundles every non-clock signal of wb_retire_unit.
// Ports (signals):
//   stall[5:0], flush              pipeline control into WB
//   mem_valid/pc/rf_we/rf_waddr/rf_wdata, mem_hi_*/mem_lo_*   per-lane retire group from MEM
//   rf_we/rf_waddr/rf_wdata, hi_*/lo_*                        regfile and HI/LO write ports
//   fwd_*                                                     bypass copy of the write ports for ID
//   stallreq_wb                                               trace FIFO back-pressure
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata                       serialised retire trace
// Modports: master = environment side, slave = wb_retire_unit side.
interface wb_retire_unit_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [5:0]             stall;
  logic                   flush;
  logic [LANES-1:0]       mem_valid;
  logic [LANES*32-1:0]    mem_pc;
  logic [LANES-1:0]       mem_rf_we;
  logic [LANES*ADDR_W-1:0] mem_rf_waddr;
  logic [LANES*DATA_W-1:0] mem_rf_wdata;
  logic                   mem_hi_we;
  logic [DATA_W-1:0]      mem_hi_wdata;
  logic                   mem_lo_we;
  logic [DATA_W-1:0]      mem_lo_wdata;

  logic [LANES-1:0]       rf_we;
  logic [LANES*ADDR_W-1:0] rf_waddr;
  logic [LANES*DATA_W-1:0] rf_wdata;
  logic                   hi_we;
  logic [DATA_W-1:0]      hi_wdata;
  logic                   lo_we;
  logic [DATA_W-1:0]      lo_wdata;

  logic [LANES-1:0]       fwd_rf_we;
  logic [LANES*ADDR_W-1:0] fwd_rf_waddr;
  logic [LANES*DATA_W-1:0] fwd_rf_wdata;
  logic                   fwd_hi_we;
  logic [DATA_W-1:0]      fwd_hi_wdata;
  logic                   fwd_lo_we;
  logic [DATA_W-1:0]      fwd_lo_wdata;

  logic                   stallreq_wb;
  logic [31:0]            debug_wb_pc;
  logic [3:0]             debug_wb_rf_wen;
  logic [4:0]             debug_wb_rf_wnum;
  logic [31:0]            debug_wb_rf_wdata;

  modport master (
    output stall, flush, mem_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
           mem_hi_we, mem_hi_wdata, mem_lo_we, mem_lo_wdata,
    input  rf_we, rf_waddr, rf_wdata, hi_we, hi_wdata, lo_we, lo_wdata,
           fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata, fwd_hi_we, fwd_hi_wdata, fwd_lo_we, fwd_lo_wdata,
           stallreq_wb, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  stall, flush, mem_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
           mem_hi_we, mem_hi_wdata, mem_lo_we, mem_lo_wdata,
    output rf_we, rf_waddr, rf_wdata, hi_we, hi_wdata, lo_we, lo_wdata,
           fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata, fwd_hi_we, fwd_hi_wdata, fwd_lo_we, fwd_lo_wdata,
           stallreq_wb, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_retire_unit.sv
// rtl/wb_retire_unit.sv - multi-lane write-back stage with regfile/bypass ports and debug trace FIFO
// Purpose: registers a LANES-wide retire group, resolves same-address conflicts, drives regfile,
//          HI/LO and bypass ports, and serialises retired lanes onto the debug_wb_* trace.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - wb_retire_unit_if.slave (MEM group in, write ports / bypass / trace / stallreq out)
module wb_retire_unit #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  wb_retire_unit_if.slave     bus
);
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Stage register
  logic [LANES-1:0]        r_valid;
  logic [LANES-1:0]        r_we;
  logic [LANES*ADDR_W-1:0] r_waddr;
  logic [LANES*DATA_W-1:0] r_wdata;
  logic                    r_hi_we;
  logic [DATA_W-1:0]       r_hi_wdata;
  logic                    r_lo_we;
  logic [DATA_W-1:0]       r_lo_wdata;

  // Trace FIFO
  logic [31:0]             r_tr_pc    [TRACE_DEPTH];
  logic [TRACE_DEPTH-1:0]  r_tr_we;
  logic [ADDR_W-1:0]       r_tr_waddr [TRACE_DEPTH];
  logic [DATA_W-1:0]       r_tr_wdata [TRACE_DEPTH];
  logic [PTR_W-1:0]        r_rptr;
  logic [PTR_W-1:0]        r_wptr;
  logic [CNT_W-1:0]        r_count;

  logic                    w_capture;
  logic                    w_bubble;
  logic [LANES-1:0]        w_rf_we;
  logic                    w_any_valid;
  logic [PTR_W-1:0]        w_slot [LANES];
  logic [CNT_W-1:0]        w_nvalid;
  logic [CNT_W-1:0]        w_npush;
  logic                    w_pop;
  logic [CNT_W:0]          w_room;
  logic [CNT_W:0]          w_count_next_wide;
  logic                    w_unused_stall;

  // stall[4] has priority over flush; stall[5] selects hold vs bubble while WB is stopped.
  assign w_capture = ~bus.stall[4] & ~bus.flush;
  assign w_bubble  = bus.stall[4] ? ~bus.stall[5] : bus.flush;
  assign w_unused_stall = ^bus.stall[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_we       <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_hi_we    <= 1'b0;
      r_hi_wdata <= '0;
      r_lo_we    <= 1'b0;
      r_lo_wdata <= '0;
    end else if (w_bubble) begin
      r_valid <= '0;
      r_we    <= '0;
      r_hi_we <= 1'b0;
      r_lo_we <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= bus.mem_valid;
      r_we       <= bus.mem_rf_we;
      r_waddr    <= bus.mem_rf_waddr;
      r_wdata    <= bus.mem_rf_wdata;
      r_hi_we    <= bus.mem_hi_we;
      r_hi_wdata <= bus.mem_hi_wdata;
      r_lo_we    <= bus.mem_lo_we;
      r_lo_wdata <= bus.mem_lo_wdata;
    end
  end

  // A younger lane writing the same register makes an older lane's write dead.
  always_comb begin
    w_rf_we = r_valid & r_we;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (r_valid[j] && r_we[j] &&
            (r_waddr[j*ADDR_W +: ADDR_W] == r_waddr[i*ADDR_W +: ADDR_W])) begin
          w_rf_we[i] = 1'b0;
        end
      end
    end
  end

  assign w_any_valid = |r_valid;

  assign bus.rf_we        = w_rf_we;
  assign bus.rf_waddr     = r_waddr;
  assign bus.rf_wdata     = r_wdata;
  assign bus.hi_we        = r_hi_we & w_any_valid;
  assign bus.hi_wdata     = r_hi_wdata;
  assign bus.lo_we        = r_lo_we & w_any_valid;
  assign bus.lo_wdata     = r_lo_wdata;
  assign bus.fwd_rf_we    = w_rf_we;
  assign bus.fwd_rf_waddr = r_waddr;
  assign bus.fwd_rf_wdata = r_wdata;
  assign bus.fwd_hi_we    = r_hi_we & w_any_valid;
  assign bus.fwd_hi_wdata = r_hi_wdata;
  assign bus.fwd_lo_we    = r_lo_we & w_any_valid;
  assign bus.fwd_lo_wdata = r_lo_wdata;

  // Valid lanes are packed densely: lane i lands after all valid lanes below it.
  always_comb begin
    w_nvalid = '0;
    for (int i = 0; i < LANES; i++) begin
      w_slot[i] = r_wptr + PTR_W'(w_nvalid);
      w_nvalid  = w_nvalid + CNT_W'(bus.mem_valid[i]);
    end
  end

  assign w_npush = w_capture ? w_nvalid : '0;
  assign w_pop   = (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_wptr  <= r_wptr + PTR_W'(w_npush);
      r_count <= r_count + w_npush - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.mem_valid[i]) begin
          r_tr_pc[w_slot[i]]    <= bus.mem_pc[i*32 +: 32];
          r_tr_we[w_slot[i]]    <= bus.mem_rf_we[i];
          r_tr_waddr[w_slot[i]] <= bus.mem_rf_waddr[i*ADDR_W +: ADDR_W];
          r_tr_wdata[w_slot[i]] <= bus.mem_rf_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.debug_wb_pc       = w_pop ? r_tr_pc[r_rptr] : 32'd0;
  assign bus.debug_wb_rf_wen   = {4{w_pop & r_tr_we[r_rptr]}};
  assign bus.debug_wb_rf_wnum  = w_pop ? 5'(r_tr_waddr[r_rptr]) : 5'd0;
  assign bus.debug_wb_rf_wdata = w_pop ? 32'(r_tr_wdata[r_rptr]) : 32'd0;

  // Room available on the next edge, counting the slot freed by this edge's pop.
  assign w_room = (CNT_W+1)'(TRACE_DEPTH) - {1'b0, r_count} + {{CNT_W{1'b0}}, w_pop};
  assign bus.stallreq_wb = (w_room < (CNT_W+1)'(LANES));

  assign w_count_next_wide = {1'b0, r_count} + {1'b0, w_npush} - (CNT_W+1)'(w_pop);

  a_trace_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_count_next_wide <= (CNT_W+1)'(TRACE_DEPTH));
endmodule

// File: tb/tb_wb_retire_unit.sv
// tb/tb_wb_retire_unit.sv - table, directed and random checks of wb_retire_unit against a queue model
module tb_wb_retire_unit;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_retire_unit_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  wb_retire_unit #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TRACE_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_t;

  // Reference model: retire group currently in WB plus the ordered list of trace entries.
  trace_t      q[$];
  logic [1:0]  m_valid, m_we;
  logic [4:0]  m_waddr [LANES];
  logic [31:0] m_wdata [LANES];
  logic        m_hi_we, m_lo_we;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [5:0]  stall; logic flush; logic [1:0] valid; logic [1:0] we;
    logic [31:0] pc0; logic [31:0] pc1; logic [4:0] a0; logic [4:0] a1;
    logic [31:0] d0; logic [31:0] d1;
    logic hi_we; logic [31:0] hi; logic lo_we; logic [31:0] lo;
    logic [1:0] e_rf_we; logic [31:0] e_wd1; logic e_hi_we; logic e_lo_we;
    logic [31:0] e_dpc; logic [3:0] e_dwen; logic [4:0] e_dnum; logic [31:0] e_ddata;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic [1:0] v, input logic [1:0] we,
                       input logic [31:0] pc0, input logic [31:0] pc1, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic hwe, input logic [31:0] hd,
                       input logic lwe, input logic [31:0] ld);
    bus.stall        = st;
    bus.flush        = fl;
    bus.mem_valid    = v;
    bus.mem_rf_we    = we;
    bus.mem_pc       = {pc1, pc0};
    bus.mem_rf_waddr = {a1, a0};
    bus.mem_rf_wdata = {d1, d0};
    bus.mem_hi_we    = hwe;
    bus.mem_hi_wdata = hd;
    bus.mem_lo_we    = lwe;
    bus.mem_lo_wdata = ld;
  endtask

  task automatic drive_idle();
    drive(6'h00, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = '0; m_we = '0; m_hi_we = 1'b0; m_lo_we = 1'b0; m_hi = '0; m_lo = '0;
    for (int i = 0; i < LANES; i++) begin m_waddr[i] = '0; m_wdata[i] = '0; end
  endtask

  function automatic bit model_stallreq();
    int room;
    room = DEPTH - q.size() + ((q.size() != 0) ? 1 : 0);
    return room < LANES;
  endfunction

  // Applies the effect of the coming clock edge to the model using the inputs now driven.
  task automatic model_edge();
    bit do_pop;
    do_pop = (q.size() != 0);
    if ((bus.stall[4] && !bus.stall[5]) || (!bus.stall[4] && bus.flush)) begin
      m_valid = '0; m_we = '0; m_hi_we = 1'b0; m_lo_we = 1'b0;
    end else if (!bus.stall[4]) begin
      m_valid = bus.mem_valid; m_we = bus.mem_rf_we;
      m_hi_we = bus.mem_hi_we; m_hi = bus.mem_hi_wdata;
      m_lo_we = bus.mem_lo_we; m_lo = bus.mem_lo_wdata;
      for (int i = 0; i < LANES; i++) begin
        m_waddr[i] = bus.mem_rf_waddr[i*5 +: 5];
        m_wdata[i] = bus.mem_rf_wdata[i*32 +: 32];
        if (bus.mem_valid[i]) q.push_back({bus.mem_pc[i*32 +: 32], bus.mem_rf_we[i], m_waddr[i], m_wdata[i]});
      end
    end
    if (do_pop) q.delete(0);
    n_vec++;
    if (q.size() > DEPTH) begin
      n_bad++;
      $display("FAIL model_overflow: got %0d entries, required at most %0d", q.size(), DEPTH);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [1:0]  e_we;
    bit   [31:0] taken;
    logic        e_hi, e_lo;
    trace_t      h;
    e_we  = '0;
    taken = '0;
    // Scan youngest to oldest: the first writer of an address keeps its write.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m_valid[i] && m_we[i]) begin
        if (!taken[m_waddr[i]]) e_we[i] = 1'b1;
        taken[m_waddr[i]] = 1'b1;
      end
    end
    chk($sformatf("%s.rf_we", tag), 64'(bus.rf_we), 64'(e_we));
    chk($sformatf("%s.fwd_rf_we", tag), 64'(bus.fwd_rf_we), 64'(e_we));
    for (int i = 0; i < LANES; i++) begin
      if (e_we[i]) begin
        chk($sformatf("%s.rf_waddr%0d", tag, i), 64'(bus.rf_waddr[i*5 +: 5]), 64'(m_waddr[i]));
        chk($sformatf("%s.rf_wdata%0d", tag, i), 64'(bus.rf_wdata[i*32 +: 32]), 64'(m_wdata[i]));
        chk($sformatf("%s.fwd_waddr%0d", tag, i), 64'(bus.fwd_rf_waddr[i*5 +: 5]), 64'(m_waddr[i]));
        chk($sformatf("%s.fwd_wdata%0d", tag, i), 64'(bus.fwd_rf_wdata[i*32 +: 32]), 64'(m_wdata[i]));
      end
    end
    e_hi = m_hi_we && (m_valid != 0);
    e_lo = m_lo_we && (m_valid != 0);
    chk($sformatf("%s.hi_we", tag), 64'(bus.hi_we), 64'(e_hi));
    chk($sformatf("%s.lo_we", tag), 64'(bus.lo_we), 64'(e_lo));
    chk($sformatf("%s.fwd_hi_we", tag), 64'(bus.fwd_hi_we), 64'(e_hi));
    chk($sformatf("%s.fwd_lo_we", tag), 64'(bus.fwd_lo_we), 64'(e_lo));
    if (e_hi) begin
      chk($sformatf("%s.hi_wdata", tag), 64'(bus.hi_wdata), 64'(m_hi));
      chk($sformatf("%s.fwd_hi_wdata", tag), 64'(bus.fwd_hi_wdata), 64'(m_hi));
    end
    if (e_lo) begin
      chk($sformatf("%s.lo_wdata", tag), 64'(bus.lo_wdata), 64'(m_lo));
      chk($sformatf("%s.fwd_lo_wdata", tag), 64'(bus.fwd_lo_wdata), 64'(m_lo));
    end
    chk($sformatf("%s.stallreq_wb", tag), 64'(bus.stallreq_wb), 64'(model_stallreq()));
    h = (q.size() != 0) ? q[0] : '0;
    chk($sformatf("%s.dbg_pc", tag), 64'(bus.debug_wb_pc), 64'(h.pc));
    chk($sformatf("%s.dbg_wen", tag), 64'(bus.debug_wb_rf_wen), 64'({4{h.we}}));
    chk($sformatf("%s.dbg_wnum", tag), 64'(bus.debug_wb_rf_wnum), 64'(h.waddr));
    chk($sformatf("%s.dbg_wdata", tag), 64'(bus.debug_wb_rf_wdata), 64'(h.wdata));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] got_pc [$];
  logic [31:0] exp_pc [$];
  logic        saw_stallreq;
  logic [5:0]  r_st;
  logic        r_fl;
  int          guard;

  initial begin
    // stall, flush, valid, we, pc0, pc1, a0, a1, d0, d1, hi_we, hi, lo_we, lo | rf_we, wd1, hi_we, lo_we, dpc, dwen, dnum, ddata
    tbl[0]  = '{6'h00, 1'b0, 2'b11, 2'b11, 32'hBFC00000, 32'hBFC00004, 5'd8, 5'd9, 32'h11, 32'h22, 1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 32'h22, 1'b0, 1'b0, 32'hBFC00000, 4'hF, 5'd8, 32'h11};
    tbl[1]  = '{6'h00, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'hBFC00004, 4'hF, 5'd9, 32'h22};
    tbl[2]  = '{6'h00, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0};
    tbl[3]  = '{6'h00, 1'b0, 2'b11, 2'b11, 32'h100, 32'h104, 5'd3, 5'd3, 32'hA, 32'hB, 1'b0, 32'h0, 1'b0, 32'h0, 2'b10, 32'hB, 1'b0, 1'b0, 32'h100, 4'hF, 5'd3, 32'hA};
    tbl[4]  = '{6'h00, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h104, 4'hF, 5'd3, 32'hB};
    tbl[5]  = '{6'h10, 1'b0, 2'b11, 2'b11, 32'h200, 32'h204, 5'd4, 5'd5, 32'h1, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0};
    tbl[6]  = '{6'h00, 1'b0, 2'b11, 2'b11, 32'h200, 32'h204, 5'd4, 5'd5, 32'h1, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 32'h2, 1'b0, 1'b0, 32'h200, 4'hF, 5'd4, 32'h1};
    tbl[7]  = '{6'h30, 1'b0, 2'b11, 2'b11, 32'h300, 32'h304, 5'd6, 5'd7, 32'h3, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 32'h2, 1'b0, 1'b0, 32'h204, 4'hF, 5'd5, 32'h2};
    tbl[8]  = '{6'h00, 1'b0, 2'b11, 2'b11, 32'h300, 32'h304, 5'd6, 5'd7, 32'h3, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 32'h4, 1'b0, 1'b0, 32'h300, 4'hF, 5'd6, 32'h3};
    tbl[9]  = '{6'h00, 1'b1, 2'b11, 2'b11, 32'h400, 32'h404, 5'd1, 5'd2, 32'h5, 32'h6, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h304, 4'hF, 5'd7, 32'h4};
    tbl[10] = '{6'h00, 1'b0, 2'b01, 2'b00, 32'h500, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 32'hDEAD, 1'b1, 32'hBEEF, 2'b00, 32'h0, 1'b1, 1'b1, 32'h500, 4'h0, 5'd0, 32'h0};
    tbl[11] = '{6'h00, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 5'd0, 32'h0};

    // Power-on reset
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("reset.rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("reset.hi_wdata", 64'(bus.hi_wdata), 64'd0);
    rst = 1'b0;

    // Directed vector table
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].stall, tbl[k].flush, tbl[k].valid, tbl[k].we, tbl[k].pc0, tbl[k].pc1, tbl[k].a0, tbl[k].a1,
            tbl[k].d0, tbl[k].d1, tbl[k].hi_we, tbl[k].hi, tbl[k].lo_we, tbl[k].lo);
      step();
      check_model($sformatf("row%0d", k));
      chk($sformatf("tbl%0d.rf_we", k), 64'(bus.rf_we), 64'(tbl[k].e_rf_we));
      if (tbl[k].e_rf_we[1]) chk($sformatf("tbl%0d.rf_wdata1", k), 64'(bus.rf_wdata[63:32]), 64'(tbl[k].e_wd1));
      chk($sformatf("tbl%0d.hi_we", k), 64'(bus.hi_we), 64'(tbl[k].e_hi_we));
      chk($sformatf("tbl%0d.lo_we", k), 64'(bus.lo_we), 64'(tbl[k].e_lo_we));
      if (tbl[k].e_hi_we) begin
        chk($sformatf("tbl%0d.hi_wdata", k), 64'(bus.hi_wdata), 64'(tbl[k].hi));
        chk($sformatf("tbl%0d.fwd_lo_wdata", k), 64'(bus.fwd_lo_wdata), 64'(tbl[k].lo));
      end
      chk($sformatf("tbl%0d.dbg_pc", k), 64'(bus.debug_wb_pc), 64'(tbl[k].e_dpc));
      chk($sformatf("tbl%0d.dbg_wen", k), 64'(bus.debug_wb_rf_wen), 64'(tbl[k].e_dwen));
      chk($sformatf("tbl%0d.dbg_wnum", k), 64'(bus.debug_wb_rf_wnum), 64'(tbl[k].e_dnum));
      chk($sformatf("tbl%0d.dbg_wdata", k), 64'(bus.debug_wb_rf_wdata), 64'(tbl[k].e_ddata));
    end

    // Reset asserted mid-stream with three trace entries pending
    drive(6'h00, 1'b0, 2'b11, 2'b11, 32'h600, 32'h604, 5'd10, 5'd11, 32'h60, 32'h61, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check_model("mrst_a");
    drive(6'h00, 1'b0, 2'b11, 2'b11, 32'h608, 32'h60C, 5'd12, 5'd13, 32'h62, 32'h63, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); check_model("mrst_b");
    chk("mrst.three_entries_no_stallreq", 64'(bus.stallreq_wb), 64'd0);
    drive_idle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_model("mrst_async");
    @(posedge clk);
    #1;
    check_model("mrst_held");
    #2;
    rst = 1'b0;
    step(); check_model("mrst_after");
    chk("mrst.dbg_wen", 64'(bus.debug_wb_rf_wen), 64'd0);

    // Four full groups back-to-back, respecting back-pressure, then drain
    saw_stallreq = 1'b0;
    got_pc.delete();
    exp_pc.delete();
    for (int g = 0; g < 4; g++) begin
      guard = 0;
      while (model_stallreq() && guard < 8) begin
        drive(6'h30, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(); check_model("burst_hold");
        if (bus.debug_wb_rf_wen != 4'h0) got_pc.push_back(bus.debug_wb_pc);
        guard++;
      end
      drive(6'h00, 1'b0, 2'b11, 2'b11, 32'h1000 + 32'(g*8), 32'h1004 + 32'(g*8), 5'(16 + g), 5'(20 + g),
            32'(g), 32'(g + 100), 1'b0, 32'h0, 1'b0, 32'h0);
      exp_pc.push_back(32'h1000 + 32'(g*8));
      exp_pc.push_back(32'h1004 + 32'(g*8));
      step(); check_model("burst_push");
      if (bus.stallreq_wb) saw_stallreq = 1'b1;
      if (bus.debug_wb_rf_wen != 4'h0) got_pc.push_back(bus.debug_wb_pc);
    end
    drive_idle();
    for (int c = 0; c < 10; c++) begin
      step(); check_model("burst_drain");
      if (bus.debug_wb_rf_wen != 4'h0) got_pc.push_back(bus.debug_wb_pc);
    end
    chk("burst.saw_stallreq", 64'(saw_stallreq), 64'd1);
    chk("burst.trace_count", 64'(got_pc.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst.trace_pc%0d", i), 64'((i < got_pc.size()) ? got_pc[i] : 32'hFFFFFFFF), 64'(exp_pc[i]));
    end

    // Randomised traffic against the model; the environment honours stallreq_wb
    for (int c = 0; c < 400; c++) begin
      r_st = 6'(($urandom_range(0, 9) == 0) ? 6'h10 : (($urandom_range(0, 9) == 0) ? 6'h30 : 6'h00));
      if (model_stallreq()) r_st = ($urandom_range(0, 1) != 0) ? 6'h30 : 6'h10;
      r_st[3:0] = 4'($urandom);
      r_fl = ($urandom_range(0, 9) == 0);
      drive(r_st, r_fl, 2'($urandom), 2'($urandom), $urandom, $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
            1'($urandom), $urandom, 1'($urandom), $urandom);
      step();
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
